// File: rtl/tt_um_spi_pkg.sv
// ============================================================================
// Module : tt_um_spi_pkg
// Desc   : Shared state encoding, pin map and divider helper for the SPI master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tt_um_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_state_t;

    localparam int START_BIT = 0;
    localparam int MISO_BIT  = 1;
    localparam int DIV_LSB   = 2;
    localparam int DIV_MSB   = 3;
    localparam int SCLK_BIT  = 4;
    localparam int MOSI_BIT  = 5;
    localparam int CS_N_BIT  = 6;
    localparam int DONE_BIT  = 7;

    localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

    // Reload value for the half-period counter: H-1 where H = 2**div.
    function automatic logic [2:0] half_m1(input logic [1:0] div);
        logic [2:0] r;
        case (div)
            2'd0:    r = 3'd0;
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_core.sv
// ============================================================================
// Module : spi_master_core
// Desc   : Mode-0, MSB-first, 8-bit SPI master with run-time clock divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_master_core
    import tt_um_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_miso,
    input  logic [1:0] i_div,
    input  logic [7:0] i_tx_data,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_done,
    output logic [7:0] o_rx_data
);

    spi_state_t state_q, state_d;
    logic       start_q, start_d;
    logic       armed_q, armed_d;
    logic [1:0] div_q, div_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] phase_q, phase_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;
    logic       done_q, done_d;

    always_comb begin
        state_d    = state_q;
        start_d    = i_start;
        // A launch needs start to have been seen low since reset.
        armed_d    = armed_q | ~i_start;
        div_d      = div_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
                if (armed_q && i_start && !start_q) begin
                    state_d    = SETUP;
                    tx_shift_d = i_tx_data;
                    div_d      = i_div;
                    cnt_d      = half_m1(i_div);
                    cs_n_d     = 1'b0;
                    mosi_d     = i_tx_data[7];
                end
            end
            SETUP: begin
                if (cnt_q == 3'd0) begin
                    state_d    = SHIFT;
                    cnt_d      = half_m1(div_q);
                    phase_d    = 4'd0;
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], i_miso};
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == 3'd0) begin
                    cnt_d = half_m1(div_q);
                    if (phase_q == 4'd15) begin
                        state_d   = DONE;
                        sclk_d    = 1'b0;
                        mosi_d    = 1'b0;
                        cs_n_d    = 1'b1;
                        done_d    = 1'b1;
                        rx_data_d = rx_shift_q;
                    end else begin
                        phase_d = phase_q + 4'd1;
                        sclk_d  = ~sclk_q;
                        if (!sclk_q) begin
                            rx_shift_d = {rx_shift_q[6:0], i_miso};
                        end else if (phase_q != 4'd14) begin
                            // The eighth falling edge leaves mosi on bit 0.
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            mosi_d     = tx_shift_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            armed_q    <= 1'b0;
            div_q      <= 2'd0;
            cnt_q      <= 3'd0;
            phase_q    <= 4'd0;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            armed_q    <= armed_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
        end
    end

    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;

endmodule

`default_nettype wire

// File: rtl/tt_um_spi.sv
// ============================================================================
// Module : tt_um_spi
// Desc   : Pin-level wrapper mapping the SPI master onto the user-module pads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tt_um_spi
    import tt_um_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    logic w_sclk;
    logic w_mosi;
    logic w_cs_n;
    logic w_done;
    logic w_unused;

    spi_master_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (uio_in[START_BIT]),
        .i_miso    (uio_in[MISO_BIT]),
        .i_div     (uio_in[DIV_MSB:DIV_LSB]),
        .i_tx_data (ui_in),
        .o_sclk    (w_sclk),
        .o_mosi    (w_mosi),
        .o_cs_n    (w_cs_n),
        .o_done    (w_done),
        .o_rx_data (uo_out)
    );

    always_comb begin
        uio_out           = 8'h00;
        uio_out[SCLK_BIT] = w_sclk;
        uio_out[MOSI_BIT] = w_mosi;
        uio_out[CS_N_BIT] = w_cs_n;
        uio_out[DONE_BIT] = w_done;
    end

    assign uio_oe   = UIO_OE_VALUE;
    assign w_unused = &{1'b0, ena, uio_in[7:4]};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_spi.sv
// ============================================================================
// Module : tb_tt_um_spi
// Desc   : Scoreboard bench for tt_um_spi using directed SPI transfers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tt_um_spi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic       start_r = 1'b0;
    logic       miso_r = 1'b0;
    logic       loopback = 1'b0;
    logic [1:0] div_r = 2'd0;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    assign uio_in = {4'b0000, div_r, (loopback ? uio_out[5] : miso_r), start_r};

    tt_um_spi dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rx;
        int         launch;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (uio_out[7] === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with uo_out=0x%0h, expected no pulse (cycle %0d)", uo_out, cyc);
            end else begin
                e = sb_q.pop_front();
                check("rx_data", {24'd0, uo_out}, {24'd0, e.rx});
                check("done_latency", cyc - e.launch, e.lat);
            end
        end
    end

    // Call at a negedge; the launch happens on the following posedge.
    task automatic launch(input logic [7:0] tx, input logic [1:0] dv,
                          input logic [7:0] exp_rx, input bit expect_done);
        ui_in   = tx;
        div_r   = dv;
        start_r = 1'b1;
        if (expect_done) sb_q.push_back('{exp_rx, cyc + 1, 17 * (1 << dv)});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         run;
        int         rises;
        int         cs_low;
        int         oe_bad;
        int         l;
        int         d_before;
        logic       prev_cs;
        logic       prev_sclk;
        logic [7:0] pat;
        bit         fin;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_uio_out", {24'd0, uio_out}, 32'h40);
        check("reset_uo_out", {24'd0, uo_out}, 32'h00);
        check("reset_uio_oe", {24'd0, uio_oe}, 32'hF0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback at div=0
        loopback = 1'b1;
        launch(8'hA5, 2'd0, 8'hA5, 1'b1);
        @(negedge clk);
        start_r = 1'b0;
        ui_in   = 8'h00;
        wait_done("loopback_complete");
        loopback = 1'b0;

        // miso=1, div=3: phase lengths and mosi order
        miso_r = 1'b1;
        pat    = 8'h3C;
        launch(pat, 2'd3, 8'hFF, 1'b1);
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
        run       = 0;
        rises     = 0;
        fin       = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            start_r = 1'b0;
            ui_in   = 8'hC3;
            if (uio_out[6] == 1'b0) begin
                if (prev_cs == 1'b0 && uio_out[4] != prev_sclk) begin
                    check("sclk_level_len", run, 8);
                    run = 1;
                    if (uio_out[4] == 1'b1) begin
                        check("mosi_at_rise", {31'd0, uio_out[5]}, {31'd0, pat[7 - (rises & 7)]});
                        rises++;
                    end
                end else begin
                    run++;
                end
            end else if (prev_cs == 1'b0) begin
                check("sclk_last_len", run, 8);
                fin = 1'b1;
            end
            prev_cs   = uio_out[6];
            prev_sclk = uio_out[4];
        end
        check("sclk_rise_count", rises, 8);
        wait_done("div3_complete");

        // Reset during the fourth sclk phase, start held through release
        miso_r = 1'b1;
        l = cyc + 1;
        launch(8'h81, 2'd1, 8'h00, 1'b0);
        @(negedge clk);
        start_r = 1'b0;
        while (cyc < l + 8) @(negedge clk);
        rst_n   = 1'b0;
        start_r = 1'b1;
        @(negedge clk);
        check("midreset_cs_n", {31'd0, uio_out[6]}, 32'd1);
        check("midreset_sclk", {31'd0, uio_out[4]}, 32'd0);
        check("midreset_uo_out", {24'd0, uo_out}, 32'h00);
        rst_n    = 1'b1;
        d_before = done_cnt;
        repeat (30) @(negedge clk);
        check("held_start_no_launch_cs", {31'd0, uio_out[6]}, 32'd1);
        check("held_start_no_done", done_cnt - d_before, 0);
        start_r = 1'b0;
        repeat (2) @(negedge clk);

        // Start held high for 100 cycles
        miso_r   = 1'b0;
        d_before = done_cnt;
        launch(8'h5A, 2'd0, 8'h00, 1'b1);
        repeat (100) @(negedge clk);
        start_r = 1'b0;
        wait_done("held_start_complete");
        repeat (5) @(negedge clk);
        check("held_start_one_done", done_cnt - d_before, 1);

        // miso=0, tx=0xFF, div=1: chip-select window and output enables
        miso_r = 1'b0;
        launch(8'hFF, 2'd1, 8'h00, 1'b1);
        cs_low  = 0;
        oe_bad  = 0;
        prev_cs = 1'b1;
        fin     = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            start_r = 1'b0;
            if (uio_oe !== 8'hF0) oe_bad++;
            if (uio_out[6] == 1'b0) cs_low++;
            else if (prev_cs == 1'b0) fin = 1'b1;
            prev_cs = uio_out[6];
        end
        check("cs_low_cycles", cs_low, 34);
        check("uio_oe_constant", oe_bad, 0);
        wait_done("div1_complete");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_um_spi.md
TT_UM_SPI -- requirements
Module: tt_um_spi

Interface
REQ-001 Parameters: none; all timing is set at run time by the divider pins.
REQ-002 Clocking and reset: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 ena  input  1  design-selected indicator; ignored by the logic.
REQ-006 ui_in  input  8  transmit byte tx_data, sampled at transfer launch.
REQ-007 uio_in  input  8  control inputs:
  - [0] start
  - [1] miso
  - [3:2] div
  - [7:4] unused
REQ-008 uio_out  output  8  serial outputs:
  - [4] sclk
  - [5] mosi
  - [6] cs_n
  - [7] done
  - [3:0] constant 0
REQ-009 uio_oe  output  8  constant 8'hF0.
REQ-010 uo_out  output  8  last received byte rx_data.

Function
REQ-011 Block is an 8-bit SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-012 Half-period H in clk cycles: div=0 gives 1, 1 gives 2, 2 gives 4, 3 gives 8; div is latched at launch.
REQ-013 start is registered each cycle; a launch occurs only on a start rising edge (current 1, previous 0) while in IDLE.
  - Holding start high never relaunches.
  - start edges outside IDLE are ignored.
REQ-014 State machine: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
REQ-015 IDLE: cs_n=1, sclk=0, mosi=0.
  - On launch (edge k): latch tx_data and div, go to SETUP.
REQ-016 SETUP: cs_n=0, sclk=0, mosi=tx_data[7]; lasts H cycles, then SHIFT.
REQ-017 SHIFT: 16 phases of H cycles each, sclk toggling at each phase boundary (8 rising, 8 falling edges).
  - On each sclk rise, miso is sampled into the receive shift register LSB.
  - On each sclk fall except the 8th, mosi advances to the next lower tx bit.
REQ-018 After the 16th phase, sclk=0 and the state enters DONE at edge k+17H.
REQ-019 DONE lasts exactly one cycle:
  - cs_n=1, done=1;
  - rx_data loads the 8 received bits (first-sampled bit becomes bit 7);
  - then IDLE.
REQ-020 done is 1 only in DONE. uo_out holds rx_data until the next DONE.
REQ-021 ui_in and miso changes outside their sampling points have no effect.
REQ-022 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-023 rst_n=0 at a clk edge forces, regardless of state (including mid-transfer):
  - state=IDLE;
  - sclk=0, mosi=0, cs_n=1, done=0;
  - rx_data=0x00, shift registers 0;
  - divider counter 0, start-history register 0.
REQ-024 A start held high through reset release does not launch; a new rising edge is required.

Structure
REQ-025 Shared package holds:
  - state enum (IDLE, SETUP, SHIFT, DONE);
  - pin index constants for start, miso, div, sclk, mosi, cs_n, done;
  - UIO_OE_VALUE = 8'hF0.
REQ-026 One sub-module, spi_master_core, contains the FSM, divider and shift registers; tt_um_spi only maps pins.

Verification
REQ-027 Loopback (miso driven from mosi), div=0, tx=0xA5, start pulse ->
  - done high exactly 17 cycles after the launch edge;
  - uo_out=0xA5.
REQ-028 miso held 1, div=3, tx=0x3C ->
  - uo_out=0xFF;
  - each sclk level lasts 8 cycles;
  - mosi sequence 0,0,1,1,1,1,0,0.
REQ-029 start held high for 100 cycles -> exactly one transfer and one done pulse.
REQ-030 rst_n low during the 4th sclk phase ->
  - next cycle cs_n=1, sclk=0, uo_out=0x00;
  - a later start transfer completes normally.
REQ-031 miso held 0, tx=0xFF, div=1 ->
  - uo_out=0x00;
  - cs_n low for exactly 34 cycles;
  - uio_oe=0xF0 throughout.
